// File: rtl/pc_sequencer_if.sv
// Bus between the fetch/jump side and the pc sequencer.
//   fetch_ready, jump_valid, jump_opcode, jump_target, jump_pc, jump_rd : requests into the sequencer
//   pc, fetch_valid, jump_ready          : fetch address and handshake flags
//   link_we, link_addr, link_data        : register-file link write
//   fault, illegal, jump_count           : status
interface pc_sequencer_if;
    logic        fetch_ready;
    logic        jump_valid;
    logic [5:0]  jump_opcode;
    logic [31:0] jump_target;
    logic [31:0] jump_pc;
    logic [4:0]  jump_rd;

    logic [31:0] pc;
    logic        fetch_valid;
    logic        jump_ready;
    logic        link_we;
    logic [4:0]  link_addr;
    logic [31:0] link_data;
    logic        fault;
    logic        illegal;
    logic [15:0] jump_count;

    // Request side (fetch memory plus jump ALU).
    modport master (
        output fetch_ready, jump_valid, jump_opcode, jump_target, jump_pc, jump_rd,
        input  pc, fetch_valid, jump_ready, link_we, link_addr, link_data,
               fault, illegal, jump_count
    );

    // Sequencer side.
    modport slave (
        input  fetch_ready, jump_valid, jump_opcode, jump_target, jump_pc, jump_rd,
        output pc, fetch_valid, jump_ready, link_we, link_addr, link_data,
               fault, illegal, jump_count
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: sequential fetch, jump redirects with link writes,
// sticky fault on misaligned targets.
//   clk, rst_n : clock and synchronous active-low reset
//   bus        : pc_sequencer_if.slave (requests in, pc/link/status out, all registered)
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input logic           clk,
    input logic           rst_n,
    pc_sequencer_if.slave bus
);

    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_JR   = 6'b001000;
    localparam logic [5:0] OP_JALR = 6'b001001;
    localparam logic [4:0] RA_REG  = 5'd31;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCH    = 2'd1,
        REDIRECT = 2'd2,
        FAULT    = 2'd3
    } state_t;

    state_t state;

    logic        accept_c;
    logic        is_jump_c;
    logic        aligned_c;
    logic        link_en_c;
    logic [4:0]  link_dst_c;

    // Request decode; jump_ready is only high in FETCH so accept implies FETCH.
    always_comb begin
        accept_c   = bus.jump_valid && bus.jump_ready;
        is_jump_c  = (bus.jump_opcode == OP_J)  || (bus.jump_opcode == OP_JAL) ||
                     (bus.jump_opcode == OP_JR) || (bus.jump_opcode == OP_JALR);
        aligned_c  = (bus.jump_target[1:0] == 2'b00);
        link_en_c  = 1'b0;
        link_dst_c = 5'd0;
        if (bus.jump_opcode == OP_JAL) begin
            link_en_c  = 1'b1;
            link_dst_c = RA_REG;
        end else if (bus.jump_opcode == OP_JALR) begin
            link_en_c  = (bus.jump_rd != 5'd0);
            link_dst_c = bus.jump_rd;
        end
    end

    // State, pc and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            bus.pc          <= RESET_PC;
            bus.fetch_valid <= 1'b0;
            bus.jump_ready  <= 1'b0;
            bus.link_we     <= 1'b0;
            bus.link_addr   <= 5'd0;
            bus.link_data   <= 32'd0;
            bus.fault       <= 1'b0;
            bus.illegal     <= 1'b0;
            bus.jump_count  <= 16'd0;
        end else begin
            // Link write and illegal are single-cycle pulses.
            bus.link_we   <= 1'b0;
            bus.link_addr <= 5'd0;
            bus.link_data <= 32'd0;
            bus.illegal   <= 1'b0;
            case (state)
                IDLE: begin
                    state           <= FETCH;
                    bus.fetch_valid <= 1'b1;
                    bus.jump_ready  <= 1'b1;
                end
                FETCH: begin
                    if (accept_c && !is_jump_c) begin
                        bus.illegal <= 1'b1;
                        if (bus.fetch_ready) begin
                            bus.pc <= bus.pc + 32'd4;
                        end
                    end else if (accept_c && !aligned_c) begin
                        state           <= FAULT;
                        bus.fault       <= 1'b1;
                        bus.fetch_valid <= 1'b0;
                        bus.jump_ready  <= 1'b0;
                    end else if (accept_c) begin
                        // Redirect beats a simultaneous sequential advance.
                        state           <= REDIRECT;
                        bus.pc          <= bus.jump_target;
                        bus.fetch_valid <= 1'b0;
                        bus.jump_ready  <= 1'b0;
                        bus.jump_count  <= bus.jump_count + 16'd1;
                        if (link_en_c) begin
                            bus.link_we   <= 1'b1;
                            bus.link_addr <= link_dst_c;
                            bus.link_data <= bus.jump_pc + 32'd8;
                        end
                    end else if (bus.fetch_ready) begin
                        bus.pc <= bus.pc + 32'd4;
                    end
                end
                REDIRECT: begin
                    state           <= FETCH;
                    bus.fetch_valid <= 1'b1;
                    bus.jump_ready  <= 1'b1;
                end
                FAULT: begin
                    // Terminal until reset; everything holds.
                    state <= FAULT;
                end
                default: begin
                    state           <= IDLE;
                    bus.fetch_valid <= 1'b0;
                    bus.jump_ready  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboarded bench for pc_sequencer: directed scenarios followed by random traffic,
// expected outputs produced by a behavioural model and checked every cycle.
module tb_pc_sequencer;

    localparam logic [31:0] RST_PC = 32'h0040_0000;

    logic clk;
    logic rst_n;
    pc_sequencer_if bus();

    pc_sequencer #(.RESET_PC(RST_PC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic        fv;
        logic        jr;
        logic        lwe;
        logic [4:0]  la;
        logic [31:0] ld;
        logic        fault;
        logic        ill;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t m;
    bit   m_boot, m_bubble, m_dead;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, want);
        end
    endtask

    // Behavioural model: outputs after the next rising edge, given this cycle's inputs.
    task automatic model_step(input bit r, input bit fr, input bit jv, input logic [5:0] op,
                              input logic [31:0] tgt, input logic [31:0] jpc, input logic [4:0] rd);
        bit busy;
        busy = m_boot || m_bubble || m_dead;
        if (!r) begin
            m = '0;
            m.pc = RST_PC;
            m_boot = 1; m_bubble = 0; m_dead = 0;
        end else begin
            m.lwe = 0; m.la = 0; m.ld = 0; m.ill = 0;
            if (m_dead) begin
                // frozen
            end else if (m_boot) begin
                m_boot = 0;
            end else if (m_bubble) begin
                m_bubble = 0;
            end else if (!busy && jv) begin
                if (!(op inside {6'd2, 6'd3, 6'd8, 6'd9})) begin
                    m.ill = 1;
                    if (fr) m.pc = m.pc + 32'd4;
                end else if (tgt[1:0] != 2'b00) begin
                    m_dead = 1;
                end else begin
                    m.pc = tgt;
                    m.cnt = m.cnt + 16'd1;
                    m_bubble = 1;
                    if (op == 6'd3 || (op == 6'd9 && rd != 5'd0)) begin
                        m.lwe = 1;
                        m.la  = (op == 6'd3) ? 5'd31 : rd;
                        m.ld  = jpc + 32'd8;
                    end
                end
            end else if (fr) begin
                m.pc = m.pc + 32'd4;
            end
        end
        m.fv    = !(m_boot || m_bubble || m_dead);
        m.jr    = m.fv;
        m.fault = m_dead;
        exp_q.push_back(m);
    endtask

    // Drive one cycle of inputs, record its expectation, advance to the next falling edge.
    task automatic cyc(input bit r, input bit fr, input bit jv, input logic [5:0] op,
                       input logic [31:0] tgt, input logic [31:0] jpc, input logic [4:0] rd);
        rst_n           = r;
        bus.fetch_ready = fr;
        bus.jump_valid  = jv;
        bus.jump_opcode = op;
        bus.jump_target = tgt;
        bus.jump_pc     = jpc;
        bus.jump_rd     = rd;
        model_step(r, fr, jv, op, tgt, jpc, rd);
        @(negedge clk);
    endtask

    task automatic idle(input int n, input bit fr);
        for (int i = 0; i < n; i++) cyc(1, fr, 0, 6'd0, 32'd0, 32'd0, 5'd0);
    endtask

    // Monitor: every cycle the DUT presents a full output vector to compare.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_empty @%0t: got 0 entries expected 1", $time);
        end else begin
            e = exp_q.pop_front();
            chk("pc",          bus.pc,                    e.pc);
            chk("fetch_valid", 32'(bus.fetch_valid),      32'(e.fv));
            chk("jump_ready",  32'(bus.jump_ready),       32'(e.jr));
            chk("link_we",     32'(bus.link_we),          32'(e.lwe));
            chk("link_addr",   32'(bus.link_addr),        32'(e.la));
            chk("link_data",   bus.link_data,             e.ld);
            chk("fault",       32'(bus.fault),            32'(e.fault));
            chk("illegal",     32'(bus.illegal),          32'(e.ill));
            chk("jump_count",  32'(bus.jump_count),       32'(e.cnt));
        end
    end

    initial begin
        m = '0; m_boot = 0; m_bubble = 0; m_dead = 0;

        // Reset then sequential fetch from the reset address.
        cyc(0, 1, 0, 6'd0, 32'd0, 32'd0, 5'd0);
        cyc(0, 1, 0, 6'd0, 32'd0, 32'd0, 5'd0);
        idle(4, 1);
        idle(2, 0);

        // jal with simultaneous fetch_ready: jump wins, link to r31.
        cyc(1, 1, 1, 6'b000011, 32'h0040_0100, 32'h0040_0010, 5'd7);
        idle(3, 1);

        // jalr with rd=0 (no link), then rd=5.
        cyc(1, 0, 1, 6'b001001, 32'h0000_0200, 32'h0040_0020, 5'd0);
        idle(2, 1);
        cyc(1, 1, 1, 6'b001001, 32'h0000_0300, 32'h0000_0204, 5'd5);
        idle(2, 0);

        // j never links.
        cyc(1, 1, 1, 6'b000010, 32'h0000_1000, 32'h0000_0300, 5'd3);
        idle(2, 1);

        // pc wrap from the top of the address space, then an illegal opcode.
        cyc(1, 0, 1, 6'b001000, 32'hFFFF_FFFC, 32'h0000_1004, 5'd0);
        idle(1, 0);
        idle(2, 1);
        cyc(1, 1, 1, 6'b000000, 32'h0000_0002, 32'h0000_0004, 5'd0);
        idle(2, 1);

        // Misaligned jr: sticky fault ignoring inputs, cleared only by reset.
        cyc(1, 1, 1, 6'b001000, 32'h0040_0102, 32'h0000_000C, 5'd0);
        cyc(1, 1, 1, 6'b000011, 32'h0000_0040, 32'h0000_0010, 5'd0);
        idle(3, 1);
        cyc(0, 1, 1, 6'b000011, 32'h0000_0040, 32'h0000_0010, 5'd0);
        idle(4, 1);

        // Reset during the REDIRECT cycle of a jal drops the link and count.
        cyc(1, 1, 1, 6'b000011, 32'h0000_0800, 32'h0040_0008, 5'd0);
        cyc(0, 1, 0, 6'd0, 32'd0, 32'd0, 5'd0);
        idle(3, 1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            bit          r, fr, jv;
            logic [5:0]  op;
            logic [31:0] tgt;
            int          sel;
            r   = ($urandom_range(0, 39) != 0);
            fr  = $urandom_range(0, 1);
            jv  = ($urandom_range(0, 3) == 0);
            sel = $urandom_range(0, 4);
            case (sel)
                0: op = 6'b000010;
                1: op = 6'b000011;
                2: op = 6'b001000;
                3: op = 6'b001001;
                default: op = 6'($urandom());
            endcase
            tgt = $urandom();
            if ($urandom_range(0, 15) != 0) tgt[1:0] = 2'b00;
            else tgt[1:0] = 2'($urandom_range(1, 3));
            cyc(r, fr, jv, op, tgt, $urandom(), 5'($urandom()));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
